// File: rtl/dma_pkg.sv
// Purpose : shared widths, APB master FSM states and the command record for the DMA register path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: REG_ADDR_WIDTH/REG_DATA_WIDTH, apb_state_e, apb_cmd_t, cnt_width() helper.
package dma_pkg;

    localparam int REG_ADDR_WIDTH = 12;
    localparam int REG_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                          write;
        logic [REG_ADDR_WIDTH-1:0]     addr;
        logic [REG_DATA_WIDTH-1:0]     wdata;
        logic [REG_DATA_WIDTH/8-1:0]   strb;
    } apb_cmd_t;

    // Width of a counter that must hold 0..t; a disabled (t == 0) counter keeps one bit.
    function automatic int cnt_width(input int t);
        return (t <= 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Purpose : synchronous command FIFO feeding the APB master FSM (head is visible while not empty).
// Latency : push visible at the head (empty deasserted) one edge after the write.
// Backpressure: full is registered; pushes while full and pops while empty are ignored.
// Ports   : clk, rst_n, push/wr_dat (write side), pop/rd_dat (read side), full, empty (registered flags).
module apb_cmd_fifo
    import dma_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = apb_cmd_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t wr_dat,
    input  logic   pop,
    output entry_t rd_dat,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);

    // One extra wrap bit per pointer: equal pointers mean empty, equal index with
    // differing wrap bits means full.
    logic [PW:0] wptr_q, wptr_d;
    logic [PW:0] rptr_q, rptr_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        do_push, do_pop;

    entry_t mem [DEPTH];

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        wptr_d  = wptr_q + (PW+1)'(do_push);
        rptr_d  = rptr_q + (PW+1)'(do_pop);
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[PW] != rptr_d[PW]) && (wptr_d[PW-1:0] == rptr_d[PW-1:0]);
    end

    // full is held high during reset so the producer sees no room until the
    // first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b1;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[PW-1:0]] <= wr_dat;
        end
    end

    assign rd_dat = mem[rptr_q[PW-1:0]];
    assign full   = full_q;
    assign empty  = empty_q;

endmodule

// File: rtl/apb_master_engine.sv
// Purpose : APB4 master turning queued register commands into APB transfers, one response per command.
// Latency : accept-to-response 3 cycles minimum, +1 per PREADY-low cycle; 4 cycles per transfer back to back.
// Backpressure: cmd_ready = !FIFO full (registered); RESP holds until rsp_ready, stalling the FIFO drain.
// Ports   : clk/rst_n; cmd_* command input (valid/ready); rsp_* response output (valid/ready);
//           busy; m_apb_* APB4 master interface.
module apb_master_engine
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH     = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = REG_DATA_WIDTH,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [DATA_WIDTH-1:0]   m_apb_pwdata,
    output logic [DATA_WIDTH/8-1:0] m_apb_pstrb,
    input  logic [DATA_WIDTH-1:0]   m_apb_prdata,
    input  logic                    m_apb_pready,
    input  logic                    m_apb_pslverr
);

    localparam int SW    = DATA_WIDTH / 8;
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    // Same layout as apb_cmd_t but sized from this instance's parameters.
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [SW-1:0]         strb;
    } cmd_t;

    cmd_t fifo_wr_dat;
    cmd_t fifo_head;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic cmd_push;

    apb_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
    logic                  pwrite_q,  pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
    logic [SW-1:0]         pstrb_q,   pstrb_d;
    logic                  psel_q,    psel_d;
    logic                  penable_q, penable_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_slverr_q,  rsp_slverr_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  busy_q,        busy_d;
    logic                  timeout_hit;

    assign cmd_ready = !fifo_full;
    assign cmd_push  = cmd_valid && !fifo_full;

    always_comb begin
        fifo_wr_dat       = '0;
        fifo_wr_dat.write = cmd_write;
        fifo_wr_dat.addr  = cmd_addr;
        fifo_wr_dat.wdata = cmd_wdata;
        fifo_wr_dat.strb  = cmd_strb;
    end

    apb_cmd_fifo #(
        .DEPTH   (CMD_DEPTH),
        .entry_t (cmd_t)
    ) u_cmd_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (cmd_push),
        .wr_dat (fifo_wr_dat),
        .pop    (fifo_pop),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Terminal count is checked only while PREADY is low, so a PREADY on the
    // last allowed cycle still completes normally.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        fifo_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    paddr_d  = fifo_head.addr;
                    pwrite_d = fifo_head.write;
                    pwdata_d = fifo_head.wdata;
                    pstrb_d  = fifo_head.write ? fifo_head.strb : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                if (m_apb_pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : m_apb_prdata;
                    rsp_slverr_d  = m_apb_pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pop in IDLE always moves the FSM out of IDLE, so the FIFO becoming
        // empty never hides outstanding work.
        busy_d = (state_d != IDLE) || cmd_push || !fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign m_apb_paddr   = paddr_q;
    assign m_apb_psel    = psel_q;
    assign m_apb_penable = penable_q;
    assign m_apb_pwrite  = pwrite_q;
    assign m_apb_pwdata  = pwdata_q;
    assign m_apb_pstrb   = pstrb_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_slverr    = rsp_slverr_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_apb_master_engine.sv
// Purpose : directed bench for apb_master_engine with a scoreboard of expected responses.
// Latency : n/a.
// Backpressure: exercised through rsp_ready and a full command FIFO.
module tb_apb_master_engine;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
    logic          busy;
    logic [AW-1:0] m_apb_paddr;
    logic          m_apb_psel;
    logic          m_apb_penable;
    logic          m_apb_pwrite;
    logic [DW-1:0] m_apb_pwdata;
    logic [SW-1:0] m_apb_pstrb;
    logic [DW-1:0] m_apb_prdata;
    logic          m_apb_pready;
    logic          m_apb_pslverr;

    always #5 clk = ~clk;

    apb_master_engine #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .CMD_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_strb      (cmd_strb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_slverr    (rsp_slverr),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy),
        .m_apb_paddr   (m_apb_paddr),
        .m_apb_psel    (m_apb_psel),
        .m_apb_penable (m_apb_penable),
        .m_apb_pwrite  (m_apb_pwrite),
        .m_apb_pwdata  (m_apb_pwdata),
        .m_apb_pstrb   (m_apb_pstrb),
        .m_apb_prdata  (m_apb_prdata),
        .m_apb_pready  (m_apb_pready),
        .m_apb_pslverr (m_apb_pslverr)
    );

    // One entry per accepted command: slave behaviour for that transfer plus the
    // response and ACCESS length the bench expects from it.
    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int            ws;
        bit            err;
        logic [DW-1:0] rdata;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        bit            exp_to;
        int            exp_pen;
    } txn_t;

    txn_t sb[$];
    txn_t mon_t;

    int checks = 0;
    int errors = 0;
    int pen_cnt = 0;
    int gap = 0;
    bit prev_psel = 1'b0;
    bit seen_xfer = 1'b0;
    int acc_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int ws, input bit err,
                        input logic [DW-1:0] rd);
        txn_t t;
        int   budget;
        t.write     = w;
        t.addr      = a;
        t.wdata     = d;
        t.strb      = s;
        t.ws        = ws;
        t.err       = err;
        t.rdata     = rd;
        t.exp_to    = (ws >= TO);
        t.exp_pen   = t.exp_to ? TO : ws + 1;
        t.exp_rdata = (w || t.exp_to) ? '0 : rd;
        t.exp_err   = err && !t.exp_to;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        budget = 200;
        while (!cmd_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            chk("cmd_ready_wait", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
        end else begin
            sb.push_back(t);
            tick();
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = 400;
        while ((sb.size() != 0 || busy) && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    // APB slave model: behaviour of the transfer in flight comes from the scoreboard head.
    initial begin
        m_apb_pready  = 1'b0;
        m_apb_pslverr = 1'b0;
        m_apb_prdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_apb_psel && m_apb_penable && sb.size() > 0) begin
                m_apb_pready  = (acc_cnt >= sb[0].ws);
                m_apb_pslverr = (acc_cnt >= sb[0].ws) && sb[0].err;
                m_apb_prdata  = sb[0].rdata;
                acc_cnt++;
            end else begin
                acc_cnt       = 0;
                m_apb_pready  = 1'b0;
                m_apb_pslverr = 1'b0;
                m_apb_prdata  = '0;
            end
        end
    end

    // Bus and response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_apb_psel) begin
                    if (!prev_psel && seen_xfer) chk("psel_gap", gap >= 1, 1'b1);
                    if (sb.size() == 0) begin
                        chk("psel_unexpected", m_apb_psel, 1'b0);
                    end else begin
                        chk("paddr", m_apb_paddr, sb[0].addr);
                        chk("pwrite", m_apb_pwrite, sb[0].write);
                        chk("pstrb", m_apb_pstrb, sb[0].write ? sb[0].strb : '0);
                        if (sb[0].write) chk("pwdata", m_apb_pwdata, sb[0].wdata);
                    end
                    if (m_apb_penable) pen_cnt++;
                    seen_xfer = 1'b1;
                    gap = 0;
                end else begin
                    gap++;
                end
                prev_psel = m_apb_psel;
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", rsp_valid, 1'b0);
                    end else begin
                        mon_t = sb.pop_front();
                        chk("rsp_rdata", rsp_rdata, mon_t.exp_rdata);
                        chk("rsp_slverr", rsp_slverr, mon_t.exp_err);
                        chk("rsp_timeout", rsp_timeout, mon_t.exp_to);
                        chk("penable_cycles", pen_cnt, mon_t.exp_pen);
                    end
                    pen_cnt = 0;
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_psel", m_apb_psel, 1'b0);
        chk("rst_penable", m_apb_penable, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_paddr", m_apb_paddr, 0);
        rst_n = 1'b1;
        tick();
        chk("cmd_ready_after_rst", cmd_ready, 1'b1);

        // Single write, zero wait states, exact cycle timing
        send(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
        chk("t1_psel_edge_n", m_apb_psel, 1'b0);
        tick();
        chk("t1_psel_n1", m_apb_psel, 1'b1);
        chk("t1_penable_n1", m_apb_penable, 1'b0);
        chk("t1_pstrb", m_apb_pstrb, 4'hF);
        chk("t1_busy", busy, 1'b1);
        tick();
        chk("t1_penable_n2", m_apb_penable, 1'b1);
        chk("t1_psel_n2", m_apb_psel, 1'b1);
        tick();
        chk("t1_rsp_valid_n3", rsp_valid, 1'b1);
        chk("t1_psel_drop", m_apb_psel, 1'b0);
        chk("t1_penable_drop", m_apb_penable, 1'b0);
        chk("t1_slverr", rsp_slverr, 1'b0);
        chk("t1_timeout", rsp_timeout, 1'b0);
        tick();
        chk("t1_rsp_valid_clear", rsp_valid, 1'b0);
        chk("t1_busy_clear", busy, 1'b0);

        // Read with three wait states
        send(1'b0, 12'h010, 32'h0, 4'hF, 3, 1'b0, 32'hDEADBEEF);
        wait_done("t2");

        // FIFO fill with the response path stalled
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 12'h040 + 12'(4 * i), 32'hA5000000 + 32'(i), 4'hF, 0, 1'b0, 32'h0);
        end
        chk("t3_cmd_ready_full", cmd_ready, 1'b0);
        chk("t3_busy", busy, 1'b1);
        repeat (3) tick();
        chk("t3_rsp_held", rsp_valid, 1'b1);
        chk("t3_still_full", cmd_ready, 1'b0);
        rsp_ready = 1'b1;
        wait_done("t3");

        // Slave error followed by a normal read
        send(1'b1, 12'h0FC, 32'h12345678, 4'h3, 1, 1'b1, 32'h0);
        send(1'b0, 12'h020, 32'h0, 4'h0, 0, 1'b0, 32'hCAFEF00D);
        wait_done("t4");

        // Timeout, then PREADY on the last allowed cycle, then a timed-out write
        send(1'b0, 12'h030, 32'h0, 4'h0, 100, 1'b0, 32'h55AA55AA);
        wait_done("t5a");
        send(1'b0, 12'h034, 32'h0, 4'h0, TO - 1, 1'b0, 32'h13579BDF);
        wait_done("t5b");
        send(1'b1, 12'h038, 32'h0BADF00D, 4'hC, 100, 1'b1, 32'hFFFFFFFF);
        wait_done("t5c");

        // Reset in the middle of a waited read
        send(1'b0, 12'h010, 32'h0, 4'h0, 1000, 1'b0, 32'hDEADBEEF);
        tick();
        tick();
        tick();
        chk("t6_in_access", m_apb_penable, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_psel_rst", m_apb_psel, 1'b0);
        chk("t6_penable_rst", m_apb_penable, 1'b0);
        chk("t6_rsp_valid_rst", rsp_valid, 1'b0);
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_cmd_ready_rst", cmd_ready, 1'b0);
        sb.delete();
        pen_cnt   = 0;
        seen_xfer = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_cmd_ready_release", cmd_ready, 1'b1);
        repeat (20) tick();
        chk("t6_no_stale_rsp", rsp_valid, 1'b0);
        chk("t6_idle_psel", m_apb_psel, 1'b0);
        send(1'b0, 12'h044, 32'h0, 4'h0, 0, 1'b0, 32'h600DCAFE);
        wait_done("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
